cgram_font_writer: RTL and testbench

CGRAM_FONT_WRITER -- requirements
Module: cgram_font_writer

---
 rtl/lcd_pkg.sv | 35 +++
 rtl/lcd_bus_strobe.sv | 70 +++++++
 rtl/cgram_font_writer.sv | 161 ++++++++++++++++
 tb/tb_cgram_font_writer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared HD44780-style LCD definitions: command opcodes, writer FSM encoding, glyph geometry.
package lcd_pkg;

  localparam logic [7:0] SET_CGRAM = 8'h40;
  localparam logic [7:0] SET_DDRAM = 8'h80;

  localparam int unsigned ROWS_PER_GLYPH = 8;

  typedef enum logic [2:0] {
    IDLE,
    CMD_SETUP,
    DATA_FETCH,
    DATA_SETUP,
    STROBE_HI,
    STROBE_GAP,
    RESTORE_SETUP,
    FINISHED
  } state_t;

  // Which bus transaction the shared strobe states are currently serving.
  typedef enum logic [1:0] {
    XactCmd,
    XactData,
    XactRestore
  } xact_t;

  function automatic logic [7:0] cgram_cmd(input logic [2:0] slot);
    return SET_CGRAM | {2'b00, slot, 3'b000};
  endfunction

  function automatic logic [7:0] ddram_cmd(input logic [6:0] addr);
    return SET_DDRAM | {1'b0, addr};
  endfunction

endpackage

// File: rtl/lcd_bus_strobe.sv
// LCD enable strobe sequencer: a go pulse during the setup cycle yields E high for
// E_HIGH_CYC cycles, then E low for E_GAP_CYC cycles with done on the last gap cycle.
module lcd_bus_strobe #(
  parameter int unsigned E_HIGH_CYC = 2,
  parameter int unsigned E_GAP_CYC  = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic go,
  output logic e,
  output logic done
);

  typedef enum logic [1:0] {
    PhIdle,
    PhHigh,
    PhGap
  } phase_t;

  localparam logic [7:0] HighLast = 8'(E_HIGH_CYC - 1);
  localparam logic [7:0] GapLast  = 8'(E_GAP_CYC - 1);

  phase_t     phase_q;
  logic [7:0] cnt_q;
  logic       e_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PhIdle;
      cnt_q   <= 8'd0;
      e_q     <= 1'b0;
    end else begin
      unique case (phase_q)
        PhIdle: begin
          if (go) begin
            phase_q <= PhHigh;
            cnt_q   <= 8'd0;
            e_q     <= 1'b1;
          end
        end
        PhHigh: begin
          if (cnt_q == HighLast) begin
            phase_q <= PhGap;
            cnt_q   <= 8'd0;
            e_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        PhGap: begin
          if (cnt_q == GapLast) begin
            phase_q <= PhIdle;
            cnt_q   <= 8'd0;
          end else begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        default: begin
          phase_q <= PhIdle;
          cnt_q   <= 8'd0;
          e_q     <= 1'b0;
        end
      endcase
    end
  end

  assign e    = e_q;
  assign done = (phase_q == PhGap) && (cnt_q == GapLast);

endmodule

// File: rtl/cgram_font_writer.sv
// Streams N_GLYPHS 5x8 glyphs from an external font ROM into LCD CGRAM, then optionally
// restores the DDRAM address. BUSY spans one launch cycle and one retire cycle around the bus work.
module cgram_font_writer #(
  parameter int unsigned N_GLYPHS   = 5,
  parameter int unsigned E_HIGH_CYC = 2,
  parameter int unsigned E_GAP_CYC  = 2,
  parameter int unsigned RESTORE_EN = 1
) (
  input  logic       CLK,
  input  logic       RESETN,
  input  logic       START,
  input  logic [2:0] BASE_SLOT,
  input  logic [6:0] RET_ADDR,
  output logic [5:0] FONT_ADDR,
  input  logic [4:0] FONT_DATA,
  output logic       TLCD_E,
  output logic       TLCD_RS,
  output logic       TLCD_RW,
  output logic [7:0] TLCD_DATA,
  output logic       BUSY,
  output logic       DONE
);

  import lcd_pkg::*;

  localparam logic [5:0] LastRow = 6'(N_GLYPHS * ROWS_PER_GLYPH - 1);

  state_t     state_q;
  xact_t      xact_q;
  logic [5:0] row_q;
  logic [5:0] font_addr_q;
  logic [2:0] slot_q;
  logic [6:0] ret_q;
  logic       rs_q;
  logic       rw_q;
  logic [7:0] data_q;
  logic       busy_q;
  logic       done_q;
  logic       launch_q;

  logic strobe_go;
  logic strobe_e;
  logic strobe_done;

  assign strobe_go = (state_q == CMD_SETUP) || (state_q == DATA_SETUP) ||
                     (state_q == RESTORE_SETUP);

  lcd_bus_strobe #(
    .E_HIGH_CYC (E_HIGH_CYC),
    .E_GAP_CYC  (E_GAP_CYC)
  ) u_strobe (
    .clk  (CLK),
    .rst  (RESETN),
    .go   (strobe_go),
    .e    (strobe_e),
    .done (strobe_done)
  );

  always_ff @(posedge CLK or posedge RESETN) begin
    if (RESETN) begin
      state_q     <= IDLE;
      xact_q      <= XactCmd;
      row_q       <= 6'd0;
      font_addr_q <= 6'd0;
      slot_q      <= 3'd0;
      ret_q       <= 7'd0;
      rs_q        <= 1'b0;
      rw_q        <= 1'b1;
      data_q      <= 8'h00;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      launch_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE, FINISHED: begin
          // Requests arriving while BUSY (launch or retire cycle) are dropped.
          if (launch_q) begin
            launch_q <= 1'b0;
            state_q  <= CMD_SETUP;
            xact_q   <= XactCmd;
            rs_q     <= 1'b0;
            rw_q     <= 1'b0;
            data_q   <= cgram_cmd(slot_q);
          end else if (busy_q) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else if (START) begin
            slot_q   <= BASE_SLOT;
            ret_q    <= RET_ADDR;
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
            launch_q <= 1'b1;
          end
        end
        CMD_SETUP, RESTORE_SETUP: begin
          state_q <= STROBE_HI;
        end
        DATA_FETCH: begin
          state_q <= DATA_SETUP;
          rs_q    <= 1'b1;
          rw_q    <= 1'b0;
        end
        DATA_SETUP: begin
          // ROM row is already on the bus via the pass-through; latch it for the strobe.
          state_q <= STROBE_HI;
          data_q  <= {3'b000, FONT_DATA};
        end
        STROBE_HI, STROBE_GAP: begin
          if (strobe_done) begin
            unique case (xact_q)
              XactCmd: begin
                state_q     <= DATA_FETCH;
                xact_q      <= XactData;
                row_q       <= 6'd0;
                font_addr_q <= 6'd0;
              end
              XactData: begin
                if (row_q != LastRow) begin
                  state_q     <= DATA_FETCH;
                  row_q       <= row_q + 6'd1;
                  font_addr_q <= row_q + 6'd1;
                end else if (RESTORE_EN != 0) begin
                  state_q <= RESTORE_SETUP;
                  xact_q  <= XactRestore;
                  rs_q    <= 1'b0;
                  rw_q    <= 1'b0;
                  data_q  <= ddram_cmd(ret_q);
                end else begin
                  state_q <= FINISHED;
                  rw_q    <= 1'b1;
                end
              end
              XactRestore: begin
                state_q <= FINISHED;
                rw_q    <= 1'b1;
              end
              default: begin
                state_q <= FINISHED;
                rw_q    <= 1'b1;
              end
            endcase
          end else if ((state_q == STROBE_HI) && !strobe_e) begin
            state_q <= STROBE_GAP;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign FONT_ADDR = font_addr_q;
  assign TLCD_E    = strobe_e;
  assign TLCD_RS   = rs_q;
  assign TLCD_RW   = rw_q;
  assign TLCD_DATA = (state_q == DATA_SETUP) ? {3'b000, FONT_DATA} : data_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;

endmodule

// File: tb/tb_cgram_font_writer.sv
// Scoreboard bench: two writer instances (default timing, and wide-E without restore).
// Stimulus queues expected bus bytes and checks; a negedge monitor does all comparing.
module tb_cgram_font_writer;

  logic       clk;
  logic       rst       [2];
  logic       start     [2];
  logic [2:0] base      [2];
  logic [6:0] ret       [2];
  logic [5:0] font_addr [2];
  logic [4:0] font_data [2];
  logic       tlcd_e    [2];
  logic       tlcd_rs   [2];
  logic       tlcd_rw   [2];
  logic [7:0] tlcd_data [2];
  logic       busy      [2];
  logic       done      [2];

  int tests = 0;
  int fails = 0;

  logic [9:0]  exp_a[$];
  logic [9:0]  exp_b[$];
  string       chk_name[$];
  logic [31:0] chk_act[$];
  logic [31:0] chk_exp[$];

  int         rise_cnt [2];
  int         hi_cnt   [2];
  logic       stab_bad [2];
  logic       prev_e   [2];
  logic [9:0] prev_bus [2];

  cgram_font_writer dut_a (
    .CLK       (clk),
    .RESETN    (rst[0]),
    .START     (start[0]),
    .BASE_SLOT (base[0]),
    .RET_ADDR  (ret[0]),
    .FONT_ADDR (font_addr[0]),
    .FONT_DATA (font_data[0]),
    .TLCD_E    (tlcd_e[0]),
    .TLCD_RS   (tlcd_rs[0]),
    .TLCD_RW   (tlcd_rw[0]),
    .TLCD_DATA (tlcd_data[0]),
    .BUSY      (busy[0]),
    .DONE      (done[0])
  );

  cgram_font_writer #(
    .N_GLYPHS   (5),
    .E_HIGH_CYC (4),
    .E_GAP_CYC  (1),
    .RESTORE_EN (0)
  ) dut_b (
    .CLK       (clk),
    .RESETN    (rst[1]),
    .START     (start[1]),
    .BASE_SLOT (base[1]),
    .RET_ADDR  (ret[1]),
    .FONT_ADDR (font_addr[1]),
    .FONT_DATA (font_data[1]),
    .TLCD_E    (tlcd_e[1]),
    .TLCD_RS   (tlcd_rs[1]),
    .TLCD_RW   (tlcd_rw[1]),
    .TLCD_DATA (tlcd_data[1]),
    .BUSY      (busy[1]),
    .DONE      (done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] rom_row(input logic [5:0] a);
    logic [5:0] t;
    t = a * 6'd11 + 6'd5;
    return t[4:0] ^ {4'b0000, a[5]};
  endfunction

  // Synchronous font ROM: data valid the cycle after the address.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) font_data[i] <= rom_row(font_addr[i]);
  end

  always @(negedge clk) begin
    while (chk_name.size() > 0) begin
      string       n;
      logic [31:0] a;
      logic [31:0] e;
      n = chk_name.pop_front();
      a = chk_act.pop_front();
      e = chk_exp.pop_front();
      tests++;
      if (a !== e) begin
        fails++;
        $display("FAIL %s: got 0x%0h, want 0x%0h", n, a, e);
      end
    end
    for (int i = 0; i < 2; i++) begin
      logic [9:0] bus;
      logic [9:0] want;
      int         wexp;
      bus = {tlcd_rs[i], tlcd_rw[i], tlcd_data[i]};
      if (rst[i]) begin
        hi_cnt[i]   = 0;
        stab_bad[i] = 1'b0;
      end else begin
        if (tlcd_e[i] && !prev_e[i]) begin
          rise_cnt[i]++;
          tests++;
          if ((i == 0 ? exp_a.size() : exp_b.size()) == 0) begin
            fails++;
            $display("FAIL strobe_unexpected[%0d]: got bus 0x%0h, want no strobe", i, bus);
          end else begin
            want = (i == 0) ? exp_a.pop_front() : exp_b.pop_front();
            if (bus !== want) begin
              fails++;
              $display("FAIL bus_byte[%0d] #%0d: got rs/rw/data 0x%0h, want 0x%0h",
                       i, rise_cnt[i], bus, want);
            end
          end
        end
        if (tlcd_e[i]) begin
          hi_cnt[i]++;
          if (bus !== prev_bus[i]) stab_bad[i] = 1'b1;
        end
        if (!tlcd_e[i] && prev_e[i]) begin
          wexp = (i == 0) ? 2 : 4;
          tests += 2;
          if (hi_cnt[i] != wexp) begin
            fails++;
            $display("FAIL e_width[%0d]: got %0d cycles, want %0d", i, hi_cnt[i], wexp);
          end
          if (stab_bad[i]) begin
            fails++;
            $display("FAIL bus_stable[%0d]: got bus change while E=1, want none", i);
          end
          hi_cnt[i]   = 0;
          stab_bad[i] = 1'b0;
        end
      end
      prev_e[i]   = tlcd_e[i];
      prev_bus[i] = bus;
    end
  end

  task automatic push_chk(input string n, input logic [31:0] a, input logic [31:0] e);
    chk_name.push_back(n);
    chk_act.push_back(a);
    chk_exp.push_back(e);
  endtask

  task automatic push_exp(input int i, input logic [9:0] v);
    if (i == 0) exp_a.push_back(v);
    else exp_b.push_back(v);
  endtask

  task automatic push_stream(input int i, input logic [7:0] cmd_byte, input logic [7:0] rest_byte,
                             input bit has_rest);
    push_exp(i, {2'b00, cmd_byte});
    for (int r = 0; r < 40; r++) push_exp(i, {2'b10, 3'b000, rom_row(6'(r))});
    if (has_rest) push_exp(i, {2'b00, rest_byte});
  endtask

  task automatic check_reset_outputs(input int i, input string tag);
    push_chk({tag, "_e"}, 32'(tlcd_e[i]), 32'd0);
    push_chk({tag, "_rs"}, 32'(tlcd_rs[i]), 32'd0);
    push_chk({tag, "_rw"}, 32'(tlcd_rw[i]), 32'd1);
    push_chk({tag, "_data"}, 32'(tlcd_data[i]), 32'h00);
    push_chk({tag, "_font_addr"}, 32'(font_addr[i]), 32'd0);
    push_chk({tag, "_busy"}, 32'(busy[i]), 32'd0);
    push_chk({tag, "_done"}, 32'(done[i]), 32'd0);
  endtask

  task automatic run_load(input int i, input logic [2:0] slot, input logic [6:0] r_addr,
                          input logic [7:0] cmd_byte, input logic [7:0] rest_byte,
                          input bit has_rest, input int extra, input int exp_busy,
                          input string tag);
    int bc;
    bit fin;
    bc  = 0;
    fin = 1'b0;
    push_stream(i, cmd_byte, rest_byte, has_rest);
    @(negedge clk);
    base[i]  = slot;
    ret[i]   = r_addr;
    start[i] = 1'b1;
    @(negedge clk);
    start[i] = 1'b0;
    for (int k = 0; k < 3000 && !fin; k++) begin
      if (busy[i]) bc++;
      if (done[i]) begin
        fin = 1'b1;
      end else begin
        if (extra != 0 && k == extra) begin
          start[i] = 1'b1;
          base[i]  = ~slot;
          ret[i]   = ~r_addr;
        end else if (extra != 0 && k == extra + 1) begin
          start[i] = 1'b0;
        end
        @(negedge clk);
      end
    end
    push_chk({tag, "_completed"}, 32'(fin), 32'd1);
    push_chk({tag, "_busy_len"}, 32'(bc), 32'(exp_busy));
    push_chk({tag, "_done"}, 32'(done[i]), 32'd1);
    push_chk({tag, "_busy_low"}, 32'(busy[i]), 32'd0);
    push_chk({tag, "_rw_idle"}, 32'(tlcd_rw[i]), 32'd1);
    push_chk({tag, "_bytes_left"}, 32'((i == 0) ? exp_a.size() : exp_b.size()), 32'd0);
  endtask

  task automatic reset_mid_strobe();
    int b;
    bit hit;
    hit = 1'b0;
    push_stream(0, 8'h40, 8'h80, 1'b1);
    b = rise_cnt[0];
    @(negedge clk);
    base[0]  = 3'd0;
    ret[0]   = 7'h00;
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    for (int k = 0; k < 2000 && !hit; k++) begin
      @(negedge clk);
      #1;
      // Command strobe plus 12 data strobes.
      if (rise_cnt[0] == b + 13) hit = 1'b1;
    end
    push_chk("rst_reached_12th_data", 32'(hit), 32'd1);
    push_chk("rst_e_high_before", 32'(tlcd_e[0]), 32'd1);
    #1 rst[0] = 1'b1;
    #1 check_reset_outputs(0, "rst_mid");
    exp_a.delete();
    @(negedge clk);
    @(negedge clk);
    #1 rst[0] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i]      = 1'b1;
      start[i]    = 1'b0;
      base[i]     = 3'd0;
      ret[i]      = 7'd0;
      rise_cnt[i] = 0;
      hi_cnt[i]   = 0;
      stab_bad[i] = 1'b0;
      prev_e[i]   = 1'b0;
      prev_bus[i] = 10'd0;
    end
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs(0, "por_a");
    check_reset_outputs(1, "por_b");
    @(negedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    repeat (2) @(negedge clk);

    run_load(0, 3'd0, 7'h00, 8'h40, 8'h80, 1'b1, 0, 252, "a_default");
    run_load(0, 3'd6, 7'h25, 8'h70, 8'hA5, 1'b1, 0, 252, "a_slot6");
    run_load(0, 3'd0, 7'h11, 8'h40, 8'h91, 1'b1, 10, 252, "a_start_ignored");
    reset_mid_strobe();
    run_load(0, 3'd0, 7'h00, 8'h40, 8'h80, 1'b1, 0, 252, "a_after_reset");
    run_load(1, 3'd3, 7'h40, 8'h58, 8'h00, 1'b0, 0, 288, "b_wide_e");

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
